// File: rtl/vend_txn_sequencer.sv
// Vending transaction controller: credit accumulation, vend/cancel/timeout arbitration,
// dispense handshake and greedy one-coin-at-a-time change payout. All outputs registered.
module vend_txn_sequencer #(
    parameter int unsigned CW         = 8,
    parameter int unsigned PRICE      = 15,
    parameter int unsigned MAX_CREDIT = 30,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_valid,
    input  logic [1:0]    coin_val,
    input  logic          vend_req,
    input  logic          cancel,
    output logic          disp_req,
    input  logic          disp_ack,
    output logic          pay_req,
    output logic          pay_coin,
    input  logic          pay_ack,
    output logic [CW-1:0] credit,
    output logic          coin_reject,
    output logic          vend_done,
    output logic          txn_done,
    output logic          busy
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW:0]   MaxCredit = (CW+1)'(MAX_CREDIT);
    localparam logic [CW-1:0] Price     = CW'(PRICE);
    localparam logic [CW-1:0] Ten       = CW'(10);
    localparam logic [CW-1:0] Five      = CW'(5);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StCredit, StDispense, StPayout} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          disp_req_q, disp_req_d;
    logic          pay_req_q, pay_req_d;
    logic          pay_coin_q, pay_coin_d;
    logic          coin_reject_q, coin_reject_d;
    logic          vend_done_q, vend_done_d;
    logic          txn_done_q, txn_done_d;
    logic          busy_q, busy_d;

    logic          coin_ok;
    logic [CW-1:0] coin_amt;
    logic [CW:0]   sum;
    logic [CW-1:0] pay_amt;
    logic [CW-1:0] remain;

    always_comb begin
        coin_ok  = coin_valid && (coin_val == 2'b01 || coin_val == 2'b10);
        coin_amt = (coin_val == 2'b10) ? Ten : Five;
        sum      = {1'b0, credit_q} + {1'b0, coin_amt};
        pay_amt  = pay_coin_q ? Ten : Five;
        remain   = (credit_q >= pay_amt) ? credit_q - pay_amt : credit_q;

        state_d       = state_q;
        credit_d      = credit_q;
        cnt_d         = cnt_q;
        disp_req_d    = disp_req_q;
        pay_req_d     = pay_req_q;
        pay_coin_d    = pay_coin_q;
        // Any coin bounces unless a branch below explicitly accepts it.
        coin_reject_d = coin_valid;
        vend_done_d   = 1'b0;
        txn_done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (coin_ok) begin
                    credit_d      = coin_amt;
                    cnt_d         = '0;
                    coin_reject_d = 1'b0;
                    state_d       = StCredit;
                end
            end
            StCredit: begin
                if (cancel) begin
                    cnt_d      = '0;
                    pay_req_d  = 1'b1;
                    pay_coin_d = (credit_q >= Ten);
                    state_d    = StPayout;
                end else if (vend_req && credit_q >= Price) begin
                    cnt_d      = '0;
                    credit_d   = credit_q - Price;
                    disp_req_d = 1'b1;
                    state_d    = StDispense;
                end else begin
                    if (coin_ok && sum <= MaxCredit) begin
                        credit_d      = sum[CW-1:0];
                        coin_reject_d = 1'b0;
                    end
                    if (coin_valid || vend_req) begin
                        cnt_d = '0;
                    end else if (cnt_q == TimeoutLast) begin
                        cnt_d      = '0;
                        pay_req_d  = 1'b1;
                        pay_coin_d = (credit_q >= Ten);
                        state_d    = StPayout;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDispense: begin
                if (disp_ack) begin
                    disp_req_d  = 1'b0;
                    vend_done_d = 1'b1;
                    if (credit_q != '0) begin
                        pay_req_d  = 1'b1;
                        pay_coin_d = (credit_q >= Ten);
                        state_d    = StPayout;
                    end else begin
                        txn_done_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StPayout: begin
                if (pay_req_q && pay_ack) begin
                    pay_req_d = 1'b0;
                    credit_d  = remain;
                    if (remain == '0) begin
                        txn_done_d = 1'b1;
                        state_d    = StIdle;
                    end
                end else if (!pay_req_q) begin
                    // Request gap of one cycle between coins.
                    if (credit_q != '0) begin
                        pay_req_d  = 1'b1;
                        pay_coin_d = (credit_q >= Ten);
                    end else begin
                        txn_done_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StDispense) || (state_d == StPayout);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            cnt_q         <= '0;
            disp_req_q    <= 1'b0;
            pay_req_q     <= 1'b0;
            pay_coin_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            vend_done_q   <= 1'b0;
            txn_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            cnt_q         <= cnt_d;
            disp_req_q    <= disp_req_d;
            pay_req_q     <= pay_req_d;
            pay_coin_q    <= pay_coin_d;
            coin_reject_q <= coin_reject_d;
            vend_done_q   <= vend_done_d;
            txn_done_q    <= txn_done_d;
            busy_q        <= busy_d;
        end
    end

    assign disp_req    = disp_req_q;
    assign pay_req     = pay_req_q;
    assign pay_coin    = pay_coin_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign vend_done   = vend_done_q;
    assign txn_done    = txn_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Directed testbench for vend_txn_sequencer with hand-computed expectations.
module tb_vend_txn_sequencer;

    logic       clk = 1'b0;
    logic       rst, coin_valid, vend_req, cancel, disp_ack, pay_ack;
    logic [1:0] coin_val;
    logic       disp_req, pay_req, pay_coin, coin_reject, vend_done, txn_done, busy;
    logic [7:0] credit;

    int checks = 0;
    int passed = 0;

    vend_txn_sequencer dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
        .vend_req(vend_req), .cancel(cancel), .disp_req(disp_req), .disp_ack(disp_ack),
        .pay_req(pay_req), .pay_coin(pay_coin), .pay_ack(pay_ack), .credit(credit),
        .coin_reject(coin_reject), .vend_done(vend_done), .txn_done(txn_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_val   = v;
        tick();
        coin_valid = 1'b0;
        coin_val   = 2'b00;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask

    task automatic pulse_pay_ack();
        pay_ack = 1'b1; tick(); pay_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++; if (credit !== 8'd0) $display("FAIL reset_credit got %0d want 0", credit); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (disp_req !== 1'b0 || pay_req !== 1'b0) $display("FAIL reset_reqs got %b%b want 00", disp_req, pay_req); else passed++;
        checks++; if (coin_reject !== 1'b0 || vend_done !== 1'b0 || txn_done !== 1'b0) $display("FAIL reset_pulses got %b%b%b want 000", coin_reject, vend_done, txn_done); else passed++;
    endtask

    task automatic test_exact_vend();
        put_coin(2'b10);
        put_coin(2'b01);
        checks++; if (credit !== 8'd15) $display("FAIL exact_credit got %0d want 15", credit); else passed++;
        vend_req = 1'b1; tick(); vend_req = 1'b0;
        checks++; if (disp_req !== 1'b1 || busy !== 1'b1) $display("FAIL exact_disp_req got %b busy %b want 1 1", disp_req, busy); else passed++;
        checks++; if (credit !== 8'd0) $display("FAIL exact_after_vend got %0d want 0", credit); else passed++;
        tick(); tick();
        checks++; if (disp_req !== 1'b1) $display("FAIL exact_disp_hold got %b want 1", disp_req); else passed++;
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        checks++; if (vend_done !== 1'b1 || txn_done !== 1'b1) $display("FAIL exact_done got vd %b td %b want 1 1", vend_done, txn_done); else passed++;
        checks++; if (disp_req !== 1'b0 || busy !== 1'b0) $display("FAIL exact_idle got disp %b busy %b want 0 0", disp_req, busy); else passed++;
        tick();
        checks++; if (vend_done !== 1'b0 || txn_done !== 1'b0) $display("FAIL exact_pulse_width got vd %b td %b want 0 0", vend_done, txn_done); else passed++;
    endtask

    task automatic test_vend_change();
        put_coin(2'b10);
        put_coin(2'b10);
        checks++; if (credit !== 8'd20) $display("FAIL change_credit got %0d want 20", credit); else passed++;
        vend_req = 1'b1; tick(); vend_req = 1'b0;
        checks++; if (credit !== 8'd5 || disp_req !== 1'b1) $display("FAIL change_vend got %0d disp %b want 5 1", credit, disp_req); else passed++;
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        checks++; if (vend_done !== 1'b1 || txn_done !== 1'b0) $display("FAIL change_vend_done got vd %b td %b want 1 0", vend_done, txn_done); else passed++;
        checks++; if (pay_req !== 1'b1 || pay_coin !== 1'b0 || busy !== 1'b1) $display("FAIL change_pay got req %b coin %b busy %b want 1 0 1", pay_req, pay_coin, busy); else passed++;
        pulse_pay_ack();
        checks++; if (credit !== 8'd0 || txn_done !== 1'b1 || pay_req !== 1'b0 || busy !== 1'b0) $display("FAIL change_drain got %0d td %b req %b busy %b want 0 1 0 0", credit, txn_done, pay_req, busy); else passed++;
    endtask

    task automatic test_ceiling();
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
        checks++; if (credit !== 8'd30 || coin_reject !== 1'b0) $display("FAIL ceil_fill got %0d rej %b want 30 0", credit, coin_reject); else passed++;
        put_coin(2'b01);
        checks++; if (coin_reject !== 1'b1 || credit !== 8'd30) $display("FAIL ceil_reject got rej %b credit %0d want 1 30", coin_reject, credit); else passed++;
        pulse_cancel();
        checks++; if (pay_req !== 1'b1 || pay_coin !== 1'b1 || credit !== 8'd30) $display("FAIL ceil_cancel got req %b coin %b credit %0d want 1 1 30", pay_req, pay_coin, credit); else passed++;
        for (int i = 1; i <= 3; i++) begin
            pulse_pay_ack();
            checks++; if (credit !== 8'(30 - 10 * i) || pay_req !== 1'b0) $display("FAIL ceil_pay%0d got credit %0d req %b want %0d 0", i, credit, pay_req, 30 - 10 * i); else passed++;
            if (i < 3) begin
                tick();
                checks++; if (pay_req !== 1'b1 || pay_coin !== 1'b1) $display("FAIL ceil_rereq%0d got req %b coin %b want 1 1", i, pay_req, pay_coin); else passed++;
            end else begin
                checks++; if (txn_done !== 1'b1 || busy !== 1'b0) $display("FAIL ceil_done got td %b busy %b want 1 0", txn_done, busy); else passed++;
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        put_coin(2'b01);
        vend_req = 1'b1; tick(); vend_req = 1'b0;
        checks++; if (disp_req !== 1'b0 || busy !== 1'b0 || credit !== 8'd5) $display("FAIL tmo_vend_ignored got disp %b busy %b credit %0d want 0 0 5", disp_req, busy, credit); else passed++;
        n = 0;
        while (pay_req !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        checks++; if (n !== 1000) $display("FAIL tmo_cycles got %0d want 1000", n); else passed++;
        checks++; if (pay_req !== 1'b1 || pay_coin !== 1'b0 || credit !== 8'd5) $display("FAIL tmo_payout got req %b coin %b credit %0d want 1 0 5", pay_req, pay_coin, credit); else passed++;
        pulse_pay_ack();
        checks++; if (credit !== 8'd0 || txn_done !== 1'b1) $display("FAIL tmo_done got credit %0d td %b want 0 1", credit, txn_done); else passed++;
    endtask

    task automatic test_coin_cancel();
        put_coin(2'b10);
        coin_valid = 1'b1; coin_val = 2'b10; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; coin_val = 2'b00; cancel = 1'b0;
        checks++; if (coin_reject !== 1'b1) $display("FAIL cc_reject got %b want 1", coin_reject); else passed++;
        checks++; if (pay_req !== 1'b1 || pay_coin !== 1'b1 || credit !== 8'd10) $display("FAIL cc_refund got req %b coin %b credit %0d want 1 1 10", pay_req, pay_coin, credit); else passed++;
        pulse_pay_ack();
        checks++; if (credit !== 8'd0 || txn_done !== 1'b1) $display("FAIL cc_done got credit %0d td %b want 0 1", credit, txn_done); else passed++;
    endtask

    task automatic test_invalid_coin();
        put_coin(2'b11);
        checks++; if (coin_reject !== 1'b1 || credit !== 8'd0 || busy !== 1'b0) $display("FAIL bad_coin got rej %b credit %0d busy %b want 1 0 0", coin_reject, credit, busy); else passed++;
        tick();
        checks++; if (coin_reject !== 1'b0) $display("FAIL bad_coin_pulse got %b want 0", coin_reject); else passed++;
    endtask

    task automatic test_reset_in_payout();
        put_coin(2'b10);
        pulse_cancel();
        checks++; if (pay_req !== 1'b1) $display("FAIL rstpay_pre got %b want 1", pay_req); else passed++;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (pay_req !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) $display("FAIL rstpay_drop got req %b credit %0d busy %b want 0 0 0", pay_req, credit, busy); else passed++;
        put_coin(2'b01);
        checks++; if (credit !== 8'd5 || coin_reject !== 1'b0) $display("FAIL rstpay_idle got credit %0d rej %b want 5 0", credit, coin_reject); else passed++;
    endtask

    initial begin
        rst = 1'b1; coin_valid = 1'b0; coin_val = 2'b00; vend_req = 1'b0;
        cancel = 1'b0; disp_ack = 1'b0; pay_ack = 1'b0;
        #2;
        test_reset();
        test_exact_vend();
        test_vend_change();
        test_ceiling();
        test_timeout();
        test_coin_cancel();
        test_invalid_coin();
        test_reset_in_payout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
